// File: rtl/debounce_pkg.sv
// Shared types and defaults for the multi-channel button debouncer.
package debounce_pkg;

    localparam int unsigned CNT_W_DEFAULT = 26;

    typedef enum logic [1:0] {
        RELEASED,
        PRESSED,
        HELD
    } btn_fsm_e;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchronizer, debounce filter, press/hold FSM and event pulses.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = 1000000,
    parameter int unsigned LONG_PRESS_CYCLES = 50000000,
    parameter int unsigned REPEAT_CYCLES     = 0,
    parameter bit          ACTIVE_LOW_IN     = 1'b0,
    parameter int unsigned CNT_W             = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button_in,
    output logic btn_state,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press_pulse
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

    logic             sync_q1;
    logic             sync_q2;
    logic             level;
    logic             accept;
    logic             press_acc;
    logic             release_acc;
    logic             long_next;
    logic [CNT_W-1:0] deb_cnt;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_next;
    btn_fsm_e         state;
    btn_fsm_e         state_next;

    assign level       = sync_q2 ^ ACTIVE_LOW_IN;
    assign accept      = (level != btn_state) && (deb_cnt == DEB_LAST);
    assign press_acc   = accept & ~btn_state;
    assign release_acc = accept & btn_state;

    // Synchronizer resets to the idle (released) raw level so reset exit never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1       <= ACTIVE_LOW_IN;
            sync_q2       <= ACTIVE_LOW_IN;
            deb_cnt       <= '0;
            btn_state     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync_q1       <= button_in;
            sync_q2       <= sync_q1;
            press_pulse   <= press_acc;
            release_pulse <= release_acc;
            if (level == btn_state || accept) begin
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + CNT_W'(1);
            end
            if (accept) begin
                btn_state <= ~btn_state;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= RELEASED;
            hold_cnt         <= '0;
            long_press_pulse <= 1'b0;
        end else begin
            state            <= state_next;
            hold_cnt         <= hold_next;
            long_press_pulse <= long_next;
        end
    end

    // Release takes priority over any hold threshold reached in the same cycle.
    always_comb begin
        state_next = state;
        hold_next  = hold_cnt;
        long_next  = 1'b0;
        unique case (state)
            RELEASED: begin
                hold_next = '0;
                if (press_acc) begin
                    state_next = PRESSED;
                end
            end
            PRESSED: begin
                if (release_acc) begin
                    state_next = RELEASED;
                    hold_next  = '0;
                end else if (hold_cnt == LONG_LAST) begin
                    state_next = HELD;
                    hold_next  = '0;
                    long_next  = 1'b1;
                end else begin
                    hold_next = hold_cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (release_acc) begin
                    state_next = RELEASED;
                    hold_next  = '0;
                end else if (REPEAT_CYCLES > 0) begin
                    if (hold_cnt == REP_LAST) begin
                        hold_next = '0;
                        long_next = 1'b1;
                    end else begin
                        hold_next = hold_cnt + CNT_W'(1);
                    end
                end else if (hold_cnt != '1) begin
                    hold_next = hold_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = RELEASED;
                hold_next  = '0;
            end
        endcase
    end

endmodule

// File: rtl/multi_button_debouncer.sv
// N_CH independent debounced button channels with press/release/long-press pulses.
module multi_button_debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned N_CH              = 4,
    parameter int unsigned DEBOUNCE_CYCLES   = 1000000,
    parameter int unsigned LONG_PRESS_CYCLES = 50000000,
    parameter int unsigned REPEAT_CYCLES     = 0,
    parameter bit          ACTIVE_LOW_IN     = 1'b0,
    parameter int unsigned CNT_W             = CNT_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] button_in,
    output logic [N_CH-1:0] btn_state,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] long_press_pulse
);

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
            .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
            .REPEAT_CYCLES    (REPEAT_CYCLES),
            .ACTIVE_LOW_IN    (ACTIVE_LOW_IN),
            .CNT_W            (CNT_W)
        ) u_channel (
            .clk             (clk),
            .rst_n           (rst_n),
            .button_in       (button_in[ch]),
            .btn_state       (btn_state[ch]),
            .press_pulse     (press_pulse[ch]),
            .release_pulse   (release_pulse[ch]),
            .long_press_pulse(long_press_pulse[ch])
        );
    end

endmodule

// File: tb/tb_multi_button_debouncer.sv
// Directed bench: active-high and active-low builds with short debounce/hold periods.
module tb_multi_button_debouncer;

    logic       clk;
    logic       rst_n;
    logic [3:0] btn;
    logic [3:0] state_o;
    logic [3:0] press_o;
    logic [3:0] release_o;
    logic [3:0] long_o;
    logic [3:0] btn_al;
    logic [3:0] state_al;
    logic [3:0] press_al;
    logic [3:0] release_al;
    logic [3:0] long_al;

    int checks = 0;
    int errors = 0;

    multi_button_debouncer #(
        .N_CH(4), .DEBOUNCE_CYCLES(8), .LONG_PRESS_CYCLES(32),
        .REPEAT_CYCLES(16), .ACTIVE_LOW_IN(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .button_in(btn),
        .btn_state(state_o), .press_pulse(press_o),
        .release_pulse(release_o), .long_press_pulse(long_o)
    );

    multi_button_debouncer #(
        .N_CH(4), .DEBOUNCE_CYCLES(8), .LONG_PRESS_CYCLES(32),
        .REPEAT_CYCLES(16), .ACTIVE_LOW_IN(1'b1)
    ) dut_al (
        .clk(clk), .rst_n(rst_n), .button_in(btn_al),
        .btn_state(state_al), .press_pulse(press_al),
        .release_pulse(release_al), .long_press_pulse(long_al)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n  = 1'b1;
        btn    = 4'b0000;
        btn_al = 4'b1111;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_state", {28'd0, state_o}, 32'd0);
        chk("reset_pulses", {20'd0, press_o, release_o, long_o}, 32'd0);
        chk("reset_al", {16'd0, state_al, press_al, release_al, long_al}, 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();

        // ch0 clean press then release
        btn[0] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("ch0_press_pulse", {31'd0, press_o[0]}, {31'd0, k == 10});
            chk("ch0_state_up", {31'd0, state_o[0]}, {31'd0, k >= 10});
        end
        btn[0] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("ch0_release_pulse", {31'd0, release_o[0]}, {31'd0, k == 10});
            chk("ch0_state_down", {31'd0, state_o[0]}, {31'd0, k < 10});
            chk("ch0_no_long", {31'd0, long_o[0]}, 32'd0);
        end

        // ch1 bounces every 3 cycles, then settles high
        for (int k = 0; k < 40; k++) begin
            if (k % 3 == 0) btn[1] = ~btn[1];
            tick();
            chk("ch1_bounce_quiet", {29'd0, state_o[1], press_o[1], release_o[1]}, 32'd0);
        end
        btn[1] = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            chk("ch1_settle_press", {31'd0, press_o[1]}, {31'd0, k == 10});
        end

        // ch2 long press with auto-repeat, then release
        btn[2] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("ch2_press_pulse", {31'd0, press_o[2]}, {31'd0, k == 10});
        end
        for (int h = 1; h <= 115; h++) begin
            if (h == 101) btn[2] = 1'b0;
            tick();
            chk("ch2_long_pulse", {31'd0, long_o[2]},
                {31'd0, (h >= 32) && (h <= 100) && ((h - 32) % 16 == 0)});
            chk("ch2_release_pulse", {31'd0, release_o[2]}, {31'd0, h == 110});
        end

        // reset mid-debounce on ch3 while ch1 stays held
        btn[3] = 1'b1;
        repeat (7) tick();
        rst_n = 1'b0;
        #2;
        chk("rst_async_state", {28'd0, state_o}, 32'd0);
        chk("rst_async_pulses", {20'd0, press_o, release_o, long_o}, 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("post_rst_press", {28'd0, press_o}, (k == 10) ? 32'hA : 32'h0);
        end

        // active-low build: all four channels pressed on the same edge
        btn_al = 4'b0000;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("al_press_all", {28'd0, press_al}, (k == 10) ? 32'hF : 32'h0);
            chk("al_state_all", {28'd0, state_al}, (k >= 10) ? 32'hF : 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
